// File: rtl/framebuf_writer_pkg.sv
// Shared types for the frame buffer write path: FSM states, the register
// bundle of the writer and its reset image.
package framebuf_writer_pkg;

  localparam int          NUM_LANES      = 4;
  localparam int          VEC_W          = 16;
  localparam logic [17:0] FRAME_BASE_DEF = 18'd32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQUEST   = 2'd1,
    WRITING   = 2'd2,
    WAIT_RESP = 2'd3
  } state_e;

  typedef struct packed {
    state_e      state;
    logic        fill_bank;
    logic [2:0]  fill_word;
    logic [1:0]  lane;
    logic        drain_bank;
    logic [1:0]  full;
    logic [2:0]  beat;
    logic [17:0] req_addr;
    logic        req_valid;
    logic        wvalid;
    logic        resp_ready;
    logic        frame_done;
    logic        restart;
  } framebuf_writer_registers;

  localparam framebuf_writer_registers framebuf_writer_r_reset = '{
    state: IDLE, fill_bank: 1'b0, fill_word: 3'd0, lane: 2'd0, drain_bank: 1'b0,
    full: 2'b00, beat: 3'd0, req_addr: FRAME_BASE_DEF, req_valid: 1'b0,
    wvalid: 1'b0, resp_ready: 1'b0, frame_done: 1'b0, restart: 1'b0
  };

endpackage

// File: rtl/framebuf_writer_if.sv
// Pixel stream, write request, write data and completion signals of the writer.
// Names are seen from the writer: i_* flow into it, o_* flow out.
interface framebuf_writer_if;
  logic        i_pix_valid;
  logic        i_pix_sof;
  logic [15:0] i_pix_data;
  logic        o_pix_ready;
  logic        o_req_valid;
  logic        i_req_ready;
  logic [17:0] o_req_addr;
  logic        o_wvalid;
  logic        i_wready;
  logic [63:0] o_wdata;
  logic        o_wlast;
  logic        i_resp_valid;
  logic        o_resp_ready;
  logic        o_frame_done;

  modport slave (
    input  i_pix_valid, i_pix_sof, i_pix_data, i_req_ready, i_wready, i_resp_valid,
    output o_pix_ready, o_req_valid, o_req_addr, o_wvalid, o_wdata, o_wlast,
           o_resp_ready, o_frame_done
  );

  modport master (
    output i_pix_valid, i_pix_sof, i_pix_data, i_req_ready, i_wready, i_resp_valid,
    input  o_pix_ready, o_req_valid, o_req_addr, o_wvalid, o_wdata, o_wlast,
           o_resp_ready, o_frame_done
  );
endinterface

// File: rtl/framebuf_writer_ram.sv
// Ping-pong line storage: 16 words of 4 x 16-bit lanes, per-lane write
// enable, registered read.
module pingpong_ram64 #(
  parameter int NUM_LANES = 4,
  parameter int VEC_W     = 16,
  parameter int DEPTH     = 16,
  parameter int AW        = 4
) (
  input  logic                             i_clk,
  input  logic [NUM_LANES-1:0]             i_we,
  input  logic [AW-1:0]                    i_waddr,
  input  logic [VEC_W-1:0]                 i_wdata,
  input  logic [AW-1:0]                    i_raddr,
  output logic [NUM_LANES-1:0][VEC_W-1:0]  o_rdata
);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [VEC_W-1:0] mem_q [DEPTH];
    logic [VEC_W-1:0] rd_q;

    always_ff @(posedge i_clk) begin
      if (i_we[l]) mem_q[i_waddr] <= i_wdata;
      rd_q <= mem_q[i_raddr];
    end

    assign o_rdata[l] = rd_q;
  end

endmodule

// File: rtl/framebuf_writer.sv
// Packs RGB565 pixels into 64 B lines in a ping-pong buffer and writes each
// full line to the frame buffer as one 8-beat addressed burst.
module framebuf_writer
  import framebuf_writer_pkg::*;
#(
  parameter logic [17:0] FRAME_BASE  = 18'd32,
  parameter logic [17:0] FRAME_LINES = 18'd9600
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  framebuf_writer_if.slave  bus
);

  localparam logic [17:0] LAST_ADDR = FRAME_BASE + FRAME_LINES - 18'd1;

  framebuf_writer_registers r_q, r_d;

  logic                             pix_ready, pix_fire, sof_fire;
  logic [NUM_LANES-1:0]             ram_we;
  logic [3:0]                       ram_waddr, ram_raddr;
  logic [NUM_LANES-1:0][VEC_W-1:0]  ram_rdata;

  assign pix_ready = ~r_q.full[r_q.fill_bank];
  assign pix_fire  = bus.i_pix_valid & pix_ready;
  assign sof_fire  = pix_fire & bus.i_pix_sof;

  // A frame start always lands at lane 0 of word 0, dropping any partial line.
  assign ram_we    = pix_fire ? (sof_fire ? 4'b0001 : (4'b0001 << r_q.lane)) : 4'b0000;
  assign ram_waddr = {r_q.fill_bank, sof_fire ? 3'd0 : r_q.fill_word};
  // Next-state beat is read so the data register is loaded when o_wvalid rises.
  assign ram_raddr = {r_d.drain_bank, r_d.beat};

  pingpong_ram64 #(.NUM_LANES(NUM_LANES), .VEC_W(VEC_W), .DEPTH(16), .AW(4)) u_ram (
    .i_clk   (i_clk),
    .i_we    (ram_we),
    .i_waddr (ram_waddr),
    .i_wdata (bus.i_pix_data),
    .i_raddr (ram_raddr),
    .o_rdata (ram_rdata)
  );

  always_comb begin
    r_d            = r_q;
    r_d.frame_done = 1'b0;

    if (sof_fire) begin
      r_d.fill_word = 3'd0;
      r_d.lane      = 2'd1;
      r_d.restart   = 1'b1;
    end else if (pix_fire) begin
      r_d.lane = r_q.lane + 2'd1;
      if (r_q.lane == 2'd3) begin
        r_d.fill_word = r_q.fill_word + 3'd1;
        if (r_q.fill_word == 3'd7) begin
          r_d.full[r_q.fill_bank] = 1'b1;
          r_d.fill_bank           = ~r_q.fill_bank;
        end
      end
    end

    case (r_q.state)
      IDLE: if (r_q.full[r_q.drain_bank]) begin
        r_d.state     = REQUEST;
        r_d.req_valid = 1'b1;
        // The first line issued after a frame start goes to the frame base.
        if (r_d.restart) begin
          r_d.req_addr = FRAME_BASE;
          r_d.restart  = 1'b0;
        end
      end
      REQUEST: if (bus.i_req_ready) begin
        r_d.state     = WRITING;
        r_d.req_valid = 1'b0;
        r_d.wvalid    = 1'b1;
        r_d.beat      = 3'd0;
      end
      WRITING: if (bus.i_wready) begin
        if (r_q.beat == 3'd7) begin
          r_d.state      = WAIT_RESP;
          r_d.wvalid     = 1'b0;
          r_d.resp_ready = 1'b1;
        end else begin
          r_d.beat = r_q.beat + 3'd1;
        end
      end
      WAIT_RESP: if (bus.i_resp_valid) begin
        r_d.state                = IDLE;
        r_d.resp_ready           = 1'b0;
        r_d.full[r_q.drain_bank] = 1'b0;
        r_d.drain_bank           = ~r_q.drain_bank;
        r_d.frame_done           = (r_q.req_addr == LAST_ADDR);
        r_d.req_addr             = (r_q.req_addr == LAST_ADDR) ? FRAME_BASE
                                                               : r_q.req_addr + 18'd1;
      end
      default: r_d.state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_q          <= framebuf_writer_r_reset;
      r_q.req_addr <= FRAME_BASE;
    end else begin
      r_q <= r_d;
    end
  end

  assign bus.o_pix_ready  = pix_ready;
  assign bus.o_req_valid  = r_q.req_valid;
  assign bus.o_req_addr   = r_q.req_valid ? r_q.req_addr : 18'd0;
  assign bus.o_wvalid     = r_q.wvalid;
  assign bus.o_wdata      = r_q.wvalid ? ram_rdata : 64'd0;
  assign bus.o_wlast      = r_q.wvalid & (r_q.beat == 3'd7);
  assign bus.o_resp_ready = r_q.resp_ready;
  assign bus.o_frame_done = r_q.frame_done;

endmodule

// File: tb/tb_framebuf_writer.sv
// Directed/randomized bench for framebuf_writer: pixels feed a line-level
// model that predicts every burst (address and beats) the writer must emit.
module tb_framebuf_writer;

  localparam logic [17:0] BASE  = 18'd32;
  localparam logic [17:0] LINES = 18'd6;

  typedef struct packed { logic sof; logic [15:0] d; } pix_t;
  typedef struct packed { logic [17:0] addr; logic [7:0][63:0] d; } burst_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  framebuf_writer_if bus();

  framebuf_writer #(.FRAME_BASE(BASE), .FRAME_LINES(LINES)) dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .bus    (bus)
  );

  pix_t        pend[$];
  burst_t      exp_q[$];
  logic [15:0] line[$];
  logic [17:0] m_addr;
  int          m_frames, frames_seen, accepted, beat_i;
  int          nchk, npass;
  int          vld_pct, rq_pct, wr_pct, rs_pct;
  logic        stall_w, stall_r;
  logic [63:0] prev_wdata;
  logic [17:0] prev_raddr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Line-level model: 32 accepted pixels make one burst at the running line index.
  task automatic model_push(input pix_t p);
    burst_t b;
    if (p.sof) begin
      line.delete();
      m_addr = BASE;
    end
    line.push_back(p.d);
    if (line.size() == 32) begin
      b.addr = m_addr;
      for (int k = 0; k < 8; k++)
        b.d[k] = {line[4*k+3], line[4*k+2], line[4*k+1], line[4*k]};
      exp_q.push_back(b);
      line.delete();
      if (m_addr == BASE + LINES - 18'd1) begin
        m_addr = BASE;
        m_frames++;
      end else begin
        m_addr = m_addr + 18'd1;
      end
    end
  endtask

  task automatic tick();
    logic pv;
    @(negedge clk);
    pv = (pend.size() > 0) && ($urandom_range(99) < vld_pct);
    bus.i_pix_valid  = pv;
    bus.i_pix_sof    = pv ? pend[0].sof : 1'b0;
    bus.i_pix_data   = pv ? pend[0].d : 16'h0;
    bus.i_req_ready  = ($urandom_range(99) < rq_pct);
    bus.i_wready     = ($urandom_range(99) < wr_pct);
    bus.i_resp_valid = ($urandom_range(99) < rs_pct);
    if (nrst) begin
      if (stall_w) begin
        chk("wvalid_hold", {63'd0, bus.o_wvalid}, 64'd1);
        chk("wdata_hold", bus.o_wdata, prev_wdata);
      end
      if (stall_r) chk("req_hold", {45'd0, bus.o_req_valid, bus.o_req_addr}, {45'd0, 1'b1, prev_raddr});
      if (pv && bus.o_pix_ready) begin
        model_push(pend.pop_front());
        accepted++;
      end
      if (bus.o_req_valid && bus.i_req_ready) begin
        chk("req_pending", {63'd0, exp_q.size() > 0}, 64'd1);
        if (exp_q.size() > 0) chk("req_addr", {46'd0, bus.o_req_addr}, {46'd0, exp_q[0].addr});
      end
      if (bus.o_wvalid && bus.i_wready) begin
        chk("beat_pending", {63'd0, exp_q.size() > 0}, 64'd1);
        if (exp_q.size() > 0) begin
          chk($sformatf("wdata_b%0d", beat_i), bus.o_wdata, exp_q[0].d[beat_i]);
          chk("wlast", {63'd0, bus.o_wlast}, {63'd0, beat_i == 7});
          beat_i++;
          if (beat_i == 8) begin
            beat_i = 0;
            void'(exp_q.pop_front());
          end
        end
      end
      if (bus.o_frame_done) frames_seen++;
      stall_w    = bus.o_wvalid & ~bus.i_wready;
      stall_r    = bus.o_req_valid & ~bus.i_req_ready;
      prev_wdata = bus.o_wdata;
      prev_raddr = bus.o_req_addr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    pend.delete(); exp_q.delete(); line.delete();
    m_addr = BASE; beat_i = 0; accepted = 0; frames_seen = 0; m_frames = 0;
    stall_w = 1'b0; stall_r = 1'b0;
    tick();
    chk("rst_pix_ready", {63'd0, bus.o_pix_ready}, 64'd1);
    chk("rst_req", {45'd0, bus.o_req_valid, bus.o_req_addr}, 64'd0);
    chk("rst_wdata", bus.o_wdata, 64'd0);
    chk("rst_ctl", {60'd0, bus.o_wvalid, bus.o_wlast, bus.o_resp_ready, bus.o_frame_done}, 64'd0);
    tick();
    nrst = 1'b1;
  endtask

  task automatic add_ramp(input int n, input logic sof_first);
    for (int i = 0; i < n; i++) pend.push_back('{sof: sof_first && i == 0, d: 16'(i % 32)});
  endtask

  task automatic add_rand(input int n, input logic sof_first);
    for (int i = 0; i < n; i++) pend.push_back('{sof: sof_first && i == 0, d: 16'($urandom)});
  endtask

  task automatic drain(input string tag, input int maxc);
    int c = 0;
    while ((pend.size() > 0 || exp_q.size() > 0 || bus.o_req_valid || bus.o_wvalid ||
            bus.o_resp_ready) && c < maxc) begin
      tick();
      c++;
    end
    chk({tag, "_drained"}, {63'd0, pend.size() == 0 && exp_q.size() == 0}, 64'd1);
  endtask

  task automatic set_rates(input int v, input int rq, input int w, input int rs);
    vld_pct = v; rq_pct = rq; wr_pct = w; rs_pct = rs;
  endtask

  initial begin
    nchk = 0; npass = 0;
    bus.i_pix_valid = 0; bus.i_pix_sof = 0; bus.i_pix_data = 0;
    bus.i_req_ready = 0; bus.i_wready = 0; bus.i_resp_valid = 0;
    set_rates(100, 100, 100, 100);

    // 1: one ramp line, memory always ready
    do_reset();
    add_ramp(32, 1'b0);
    drain("t1", 400);

    // 2: request back-pressure fills both banks and stalls the stream
    do_reset();
    set_rates(100, 0, 100, 100);
    add_rand(96, 1'b0);
    repeat (150) tick();
    chk("t2_accepted", 64'(accepted), 64'd64);
    chk("t2_pix_ready", {63'd0, bus.o_pix_ready}, 64'd0);
    chk("t2_req_held", {45'd0, bus.o_req_valid, bus.o_req_addr}, {45'd0, 1'b1, BASE});
    set_rates(100, 100, 100, 100);
    drain("t2", 800);

    // 3: random stalls on every handshake over three ramp lines
    do_reset();
    set_rates(70, 50, 50, 30);
    add_ramp(96, 1'b0);
    drain("t3", 2000);

    // 4: a full (shortened) frame plus one line to see the wrap
    do_reset();
    set_rates(90, 80, 80, 80);
    add_rand(32 * (int'(LINES) + 1), 1'b1);
    drain("t4", 4000);
    chk("t4_frame_done", 64'(frames_seen), 64'(m_frames));
    chk("t4_frames", 64'(frames_seen), 64'd1);

    // 5: frame start mid-line after five lines
    do_reset();
    set_rates(100, 100, 100, 100);
    add_rand(32 * 5 + 10, 1'b0);
    drain("t5a", 1000);
    pend.push_back('{sof: 1'b1, d: 16'hBEEF});
    add_rand(31, 1'b0);
    drain("t5b", 400);

    // 6: reset during beat 3, then a clean line
    do_reset();
    set_rates(100, 100, 100, 100);
    add_ramp(32, 1'b0);
    begin
      int c = 0;
      while (!(bus.o_wvalid && beat_i == 3) && c < 200) begin tick(); c++; end
      chk("t6_reached_beat3", {63'd0, bus.o_wvalid && beat_i == 3}, 64'd1);
    end
    do_reset();
    add_ramp(32, 1'b0);
    drain("t6", 400);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
